if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 64-bit pipelined processor. Sits directly upstream of the instruction decoder/control stage.
- Owns the program counter and drives the instruction-memory address. Computes branch targets for B and CBZ redirects coming back from decode.
- Registers fetched instructions into the IF/ID pipeline register, with stall and flush.

Parameters:
- ADDR_W, 64, PC and address width.
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word held in IF/ID when invalid.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- stall  input  1  hazard-unit stall; hold PC and IF/ID.
- redirect  input  1  decode stage resolved a taken branch this cycle.
- redir_uncond  input  1  1 = B (imm26 offset), 0 = CBZ (imm19 offset).
- redir_pc  input  ADDR_W  PC of the branch instruction currently in decode.
- redir_instr  input  32  the branch instruction word currently in decode.
- imem_addr  output  ADDR_W  instruction-memory address (= PC register).
- imem_rdata  input  32  instruction word; combinational read of imem_addr in the same cycle.
- ifid_pc  output  ADDR_W  PC of the instruction held in IF/ID.
- ifid_instr  output  32  instruction held in IF/ID.
- ifid_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset:
  - Reset is synchronous and active-low: while rst_n=0 at a rising edge, PC<=RESET_PC, ifid_pc<=0, ifid_instr<=NOP_INSTR, ifid_valid<=0.
  - Reset dominates stall and redirect.
- imem_addr is always the PC register itself, not a combinational next-PC.
- Branch target:
  - B: target = redir_pc + (sext64(redir_instr[25:0]) << 2).
  - CBZ: target = redir_pc + (sext64(redir_instr[23:5]) << 2).
  - Selection is by redir_uncond. Arithmetic is modulo 2^64; wrap-around is silent. Negative offsets must sign-extend correctly.
- Per-edge priority, with rst_n=1:
  1. redirect=1: PC<=target, ifid_valid<=0, ifid_instr<=NOP_INSTR, ifid_pc<=0. The wrong-path instruction fetched this cycle is squashed. Redirect overrides stall.
  2. stall=1 (redirect=0): PC, ifid_pc, ifid_instr and ifid_valid all hold.
  3. Otherwise: ifid_pc<=PC, ifid_instr<=imem_rdata, ifid_valid<=1, PC<=PC+4.
- Latency and branch penalty:
  - Latency: an instruction at address A appears on ifid_* one edge after imem_addr=A.
  - Branch penalty: one bubble. The cycle after a redirect has ifid_valid=0. On the next non-stalled edge, the target instruction loads.
- No internal state beyond PC and the IF/ID register. There are no memory wait states; stall is the only back-pressure.
- Mid-operation reset: any pending redirect or stall is discarded. The fetch sequence restarts at RESET_PC on the first edge after rst_n returns to 1.
- Outputs are registered only. There are no combinational paths from stall or redirect to any output.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W and INSTR_W constants.
  - Opcode constants for B (6'b000101) and CBZ (8'b10110100).
  - NOP_INSTR.
  - sign-extension helper functions for imm26 and imm19.
- The decoder and this stage share the package.
- One sub-module: branch_target (combinational). Inputs are pc, instr and uncond; output is target. It is reused by any later branch-prediction work.
- The PC and IF/ID registers stay in if_stage.

Test Plan:
- Reset then release, with memory word at address 4k equal to k: after edges 1..4 post-release, ifid_pc = 0, 4, 8, 12 and ifid_instr = 0, 1, 2, 3, with ifid_valid=1 from the first post-release edge.
- stall=1 for 3 cycles while PC=8: imem_addr stays 8, and ifid_pc=4 and ifid_instr hold. After the stall drops, the next edge gives ifid_pc=8 and imem_addr=12.
- Backward B:
  - Stimulus: redirect=1, redir_uncond=1, redir_pc=0x40, redir_instr=0x17FFFFFC (imm26=-4).
  - Response: next PC=0x30 and ifid_valid=0. The following edge gives ifid_pc=0x30.
- Forward CBZ:
  - Stimulus: redirect=1, redir_uncond=0, redir_pc=0x100, redir_instr=0xB4000060 (imm19=3).
  - Response: PC=0x10C and ifid_valid=0 for one cycle.
- redirect and stall both high, with B offset +2 from redir_pc=0x20: PC becomes 0x28 and ifid_valid=0. Redirect wins over stall.
- rst_n=0 asserted mid-redirect at PC=0x200: PC=RESET_PC and ifid_valid=0, and no target is applied after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch and decode stages: widths, branch opcodes,
// the bubble instruction and immediate sign-extension helpers.
package cpu_pkg;

    localparam int          ADDR_W    = 64;
    localparam int          INSTR_W   = 32;
    localparam logic [5:0]  OPC_B     = 6'b000101;
    localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    function automatic logic signed [ADDR_W-1:0] sext_imm26(input logic [25:0] imm);
        return {{(ADDR_W-26){imm[25]}}, imm};
    endfunction

    function automatic logic signed [ADDR_W-1:0] sext_imm19(input logic [18:0] imm);
        return {{(ADDR_W-19){imm[18]}}, imm};
    endfunction

endpackage

// File: rtl/branch_target.sv
// Combinational branch-target adder: B uses imm26, CBZ uses imm19, both word offsets.
module branch_target #(
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       instr,
    input  logic              uncond,
    output logic [ADDR_W-1:0] target
);
    import cpu_pkg::*;

    logic signed [ADDR_W-1:0] w_off;

    always_comb begin
        if (uncond) begin
            w_off = ADDR_W'(sext_imm26(instr[25:0]));
        end else begin
            w_off = ADDR_W'(sext_imm19(instr[23:5]));
        end
    end

    // Modulo-2^ADDR_W add; wrap-around is intentionally silent.
    assign target = pc + ADDR_W'(w_off <<< 2);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// fills the IF/ID register, with stall hold and redirect squash.
module if_stage #(
    parameter int              ADDR_W    = cpu_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redirect,
    input  logic              redir_uncond,
    input  logic [ADDR_W-1:0] redir_pc,
    input  logic [31:0]       redir_instr,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [31:0]       ifid_instr,
    output logic              ifid_valid
);
    import cpu_pkg::*;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_ifid_pc;
    logic [31:0]       r_ifid_instr;
    logic              r_ifid_valid;
    logic [ADDR_W-1:0] w_target;

    branch_target #(
        .ADDR_W (ADDR_W)
    ) u_branch_target (
        .pc     (redir_pc),
        .instr  (redir_instr),
        .uncond (redir_uncond),
        .target (w_target)
    );

    // Reset beats redirect, redirect beats stall; a redirect squashes the wrong-path fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else if (redirect) begin
            r_pc         <= w_target;
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else if (!stall) begin
            r_pc         <= r_pc + ADDR_W'(4);
            r_ifid_pc    <= r_pc;
            r_ifid_instr <= imem_rdata;
            r_ifid_valid <= 1'b1;
        end
    end

    assign imem_addr  = r_pc;
    assign ifid_pc    = r_ifid_pc;
    assign ifid_instr = r_ifid_instr;
    assign ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed literal checks plus randomized traffic compared
// every cycle against a behavioural fetch model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic        redir_uncond = 1'b0;
    logic [63:0] redir_pc = '0;
    logic [31:0] redir_instr = '0;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [63:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [63:0] m_pc = '0;
    logic [63:0] m_ifpc = '0;
    logic [31:0] m_ifinstr = '0;
    logic        m_ifv = 1'b0;

    if_stage #(
        .ADDR_W    (64),
        .RESET_PC  (64'h0),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .redirect     (redirect),
        .redir_uncond (redir_uncond),
        .redir_pc     (redir_pc),
        .redir_instr  (redir_instr),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .ifid_pc      (ifid_pc),
        .ifid_instr   (ifid_instr),
        .ifid_valid   (ifid_valid)
    );

    always #5 clk = ~clk;

    // Memory image: the word at byte address 4k holds k.
    assign imem_rdata = imem_addr[33:2];

    function automatic logic [63:0] ref_target(input logic [63:0] pc, input logic [31:0] ins,
                                               input logic unc);
        longint off;
        if (unc) begin
            off = longint'(ins[25:0]);
            if (ins[25]) off = off - (longint'(1) << 26);
        end else begin
            off = longint'(ins[23:5]);
            if (ins[23]) off = off - (longint'(1) << 19);
        end
        return pc + 64'(off * 4);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the fetch stage, advanced on each rising edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc = 64'h0; m_ifpc = 64'h0; m_ifinstr = 32'h0; m_ifv = 1'b0;
        end else if (redirect) begin
            m_pc = ref_target(redir_pc, redir_instr, redir_uncond);
            m_ifpc = 64'h0; m_ifinstr = 32'h0; m_ifv = 1'b0;
        end else if (!stall) begin
            m_ifpc = m_pc; m_ifinstr = 32'(m_pc >> 2); m_ifv = 1'b1;
            m_pc = m_pc + 64'd4;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model imem_addr", imem_addr, m_pc);
            chk("model ifid_pc", ifid_pc, m_ifpc);
            chk("model ifid_instr", {32'h0, ifid_instr}, {32'h0, m_ifinstr});
            chk("model ifid_valid", {63'h0, ifid_valid}, {63'h0, m_ifv});
        end
    end

    task automatic cyc(input logic r, input logic st, input logic rd, input logic unc,
                       input logic [63:0] rpc, input logic [31:0] rins);
        rst_n = r; stall = st; redirect = rd; redir_uncond = unc;
        redir_pc = rpc; redir_instr = rins;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        chk_en = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 64'h40, 32'h17FF_FFFC);
        chk("reset imem_addr", imem_addr, 64'h0);
        chk("reset ifid_valid", {63'h0, ifid_valid}, 64'h0);
        chk("reset ifid_instr", {32'h0, ifid_instr}, 64'h0);

        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
            chk("seq ifid_pc", ifid_pc, 64'(4 * k));
            chk("seq ifid_instr", {32'h0, ifid_instr}, 64'(k));
            chk("seq ifid_valid", {63'h0, ifid_valid}, 64'h1);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 32'h0);
            chk("stall imem_addr", imem_addr, 64'h8);
            chk("stall ifid_pc", ifid_pc, 64'h4);
            chk("stall ifid_instr", {32'h0, ifid_instr}, 64'h1);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        chk("unstall ifid_pc", ifid_pc, 64'h8);
        chk("unstall imem_addr", imem_addr, 64'hC);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        chk("seq4 ifid_pc", ifid_pc, 64'hC);
        chk("seq4 ifid_instr", {32'h0, ifid_instr}, 64'h3);

        cyc(1'b1, 1'b0, 1'b1, 1'b1, 64'h40, 32'h17FF_FFFC);
        chk("bwd B pc", imem_addr, 64'h30);
        chk("bwd B bubble", {63'h0, ifid_valid}, 64'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        chk("bwd B ifid_pc", ifid_pc, 64'h30);
        chk("bwd B ifid_instr", {32'h0, ifid_instr}, 64'hC);

        cyc(1'b1, 1'b0, 1'b1, 1'b0, 64'h100, 32'hB400_0060);
        chk("fwd CBZ pc", imem_addr, 64'h10C);
        chk("fwd CBZ bubble", {63'h0, ifid_valid}, 64'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        chk("fwd CBZ ifid_pc", ifid_pc, 64'h10C);

        cyc(1'b1, 1'b1, 1'b1, 1'b1, 64'h20, 32'h1400_0002);
        chk("redir+stall pc", imem_addr, 64'h28);
        chk("redir+stall valid", {63'h0, ifid_valid}, 64'h0);

        cyc(1'b1, 1'b0, 1'b1, 1'b1, 64'h0, 32'h1400_0080);
        chk("jump 0x200", imem_addr, 64'h200);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 64'h200, 32'h1400_0010);
        chk("reset mid-redir pc", imem_addr, 64'h0);
        chk("reset mid-redir valid", {63'h0, ifid_valid}, 64'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        chk("post-reset ifid_pc", ifid_pc, 64'h0);
        chk("post-reset valid", {63'h0, ifid_valid}, 64'h1);
        chk("post-reset imem_addr", imem_addr, 64'h4);

        chk("wrap target", ref_target(64'h0, 32'h17FF_FFFF, 1'b1), 64'hFFFF_FFFF_FFFF_FFFC);

        for (int i = 0; i < 3000; i++) begin
            logic r, st, rd, unc;
            logic [63:0] rpc;
            r   = ($urandom_range(0, 99) >= 2);
            st  = ($urandom_range(0, 99) < 25);
            rd  = ($urandom_range(0, 99) < 15);
            unc = $urandom_range(0, 1) == 1;
            rpc = ($urandom_range(0, 3) == 0) ? {$urandom(), $urandom()}
                                              : 64'($urandom_range(0, 4095) * 4);
            cyc(r, st, rd, unc, rpc, $urandom());
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
